// File: rtl/alu_seq.sv
// Clocked WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish at accept; shifts and rotates step one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [3:0]       OPCODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DATAOUT,
  output logic [4:0]       FLAGS
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_DATA = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_ROL = 4'b1001;
  localparam logic [3:0] OP_ROR = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [3:0]         op_r, op_s;
  logic [WIDTH-1:0]   work_r, work_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH-1:0]   dataout_r, dataout_s;
  logic [4:0]         flags_r, flags_s;
  logic               in_ready_r, out_valid_r;

  logic [WIDTH:0]     sum_s, diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic [4:0]         alu_flags_s;
  logic               is_shift_s;
  logic [CNT_W-1:0]   shift_cnt_s;
  logic [WIDTH-1:0]   step_s;
  logic               step_cf_s;

  function automatic logic [4:0] pack_flags(input logic gt, input logic ovf,
                                            input logic cf, input logic nf,
                                            input logic zf);
    return {gt, ovf, cf, nf, zf};
  endfunction

  assign sum_s  = {1'b0, DATA1} + {1'b0, DATA2};
  assign diff_s = {1'b0, DATA1} - {1'b0, DATA2};
  assign is_shift_s = (OPCODE >= OP_SHL) && (OPCODE <= OP_ROR);

  // Single-cycle result and flags straight from the operand inputs.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_flags_s = 5'b00000;
    case (OPCODE)
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_flags_s = pack_flags(1'b0,
                                 (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (sum_s[WIDTH-1] != DATA1[WIDTH-1]),
                                 sum_s[WIDTH], sum_s[WIDTH-1], sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end
      OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_flags_s = pack_flags(1'b0,
                                 (DATA1[WIDTH-1] != DATA2[WIDTH-1]) && (diff_s[WIDTH-1] != DATA1[WIDTH-1]),
                                 diff_s[WIDTH], diff_s[WIDTH-1], diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
      end
      OP_AND: begin
        alu_res_s   = DATA1 & DATA2;
        alu_flags_s = pack_flags(1'b0, 1'b0, 1'b0, alu_res_s[WIDTH-1], alu_res_s == {WIDTH{1'b0}});
      end
      OP_OR: begin
        alu_res_s   = DATA1 | DATA2;
        alu_flags_s = pack_flags(1'b0, 1'b0, 1'b0, alu_res_s[WIDTH-1], alu_res_s == {WIDTH{1'b0}});
      end
      OP_XOR: begin
        alu_res_s   = DATA1 ^ DATA2;
        alu_flags_s = pack_flags(1'b0, 1'b0, 1'b0, alu_res_s[WIDTH-1], alu_res_s == {WIDTH{1'b0}});
      end
      OP_NOT: begin
        alu_res_s   = ~DATA1;
        alu_flags_s = pack_flags(1'b0, 1'b0, 1'b0, alu_res_s[WIDTH-1], alu_res_s == {WIDTH{1'b0}});
      end
      OP_CMP: begin
        // CMP only updates flags; the previous result stays on DATAOUT.
        alu_res_s   = dataout_r;
        alu_flags_s = pack_flags(DATA1 > DATA2, 1'b0, diff_s[WIDTH], 1'b0, DATA1 == DATA2);
      end
      default: begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_flags_s = 5'b00000;
      end
    endcase
  end

  // Effective shift count: logical shifts saturate at WIDTH, rotates wrap.
  always_comb begin
    shift_cnt_s = {CNT_W{1'b0}};
    if ((OPCODE == OP_SHL) || (OPCODE == OP_SHR)) begin
      if (DATA2 >= W_DATA) begin
        shift_cnt_s = CNT_W'(WIDTH);
      end else begin
        shift_cnt_s = CNT_W'(DATA2);
      end
    end else begin
      shift_cnt_s = CNT_W'(DATA2[SH_W-1:0]);
    end
  end

  // One-bit step of the working register and the bit that crosses the end.
  always_comb begin
    step_s    = work_r;
    step_cf_s = 1'b0;
    case (op_r)
      OP_SHL: begin
        step_s    = {work_r[WIDTH-2:0], 1'b0};
        step_cf_s = work_r[WIDTH-1];
      end
      OP_SHR: begin
        step_s    = {1'b0, work_r[WIDTH-1:1]};
        step_cf_s = work_r[0];
      end
      OP_ROL: begin
        step_s    = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
        step_cf_s = work_r[WIDTH-1];
      end
      OP_ROR: begin
        step_s    = {work_r[0], work_r[WIDTH-1:1]};
        step_cf_s = work_r[0];
      end
      default: begin
        step_s    = work_r;
        step_cf_s = 1'b0;
      end
    endcase
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    work_s    = work_r;
    cnt_s     = cnt_r;
    dataout_s = dataout_r;
    flags_s   = flags_r;
    case (state_r)
      IDLE: begin
        if (IN_VALID) begin
          op_s = OPCODE;
          if (is_shift_s) begin
            work_s = DATA1;
            cnt_s  = shift_cnt_s;
            if (shift_cnt_s == {CNT_W{1'b0}}) begin
              dataout_s = DATA1;
              flags_s   = pack_flags(1'b0, 1'b0, 1'b0, DATA1[WIDTH-1], DATA1 == {WIDTH{1'b0}});
              state_s   = DONE;
            end else begin
              state_s = SHIFT;
            end
          end else begin
            dataout_s = alu_res_s;
            flags_s   = alu_flags_s;
            state_s   = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        work_s = step_s;
        cnt_s  = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          dataout_s = step_s;
          flags_s   = pack_flags(1'b0, 1'b0, step_cf_s, step_s[WIDTH-1], step_s == {WIDTH{1'b0}});
          state_s   = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      op_r        <= 4'b0000;
      work_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      dataout_r   <= {WIDTH{1'b0}};
      flags_r     <= 5'b00000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      work_r      <= work_s;
      cnt_r       <= cnt_s;
      dataout_r   <= dataout_s;
      flags_r     <= flags_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign DATAOUT   = dataout_r;
  assign FLAGS     = flags_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] DATA1 = 8'h00;
  logic [7:0] DATA2 = 8'h00;
  logic [3:0] OPCODE = 4'b0000;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] DATAOUT;
  logic [4:0] FLAGS;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA1(DATA1), .DATA2(DATA2), .OPCODE(OPCODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DATAOUT(DATAOUT), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
    end
  endtask

  // Issue one op with OUT_READY held high and measure accept-to-valid latency.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int lat_exp,
                        input logic [7:0] d_exp, input logic [4:0] f_exp);
    int lat;
    @(negedge CLK);
    check({tag, "_inrdy"}, IN_READY, 1);
    OPCODE = op; DATA1 = a; DATA2 = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
    lat = 0;
    do begin
      @(negedge CLK);
      IN_VALID = 1'b0;
      lat++;
    end while (!OUT_VALID && lat < 40);
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_data"}, DATAOUT, d_exp);
    check({tag, "_flags"}, FLAGS, f_exp);
    @(negedge CLK);
    check({tag, "_vdrop"}, OUT_VALID, 0);
    check({tag, "_inrdy2"}, IN_READY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_inrdy", IN_READY, 1);
    check("rst_vld", OUT_VALID, 0);
    check("rst_data", DATAOUT, 8'h00);
    check("rst_flags", FLAGS, 5'b00000);
    RST = 1'b0;

    run_op("add",    4'b0000, 8'hF0, 8'h20, 1, 8'h10, 5'b00100);
    run_op("add_ov", 4'b0000, 8'h7F, 8'h01, 1, 8'h80, 5'b01010);
    run_op("sub",    4'b0001, 8'h05, 8'h07, 1, 8'hFE, 5'b00110);
    run_op("cmp_eq", 4'b0110, 8'h09, 8'h09, 1, 8'hFE, 5'b00001);
    run_op("cmp_gt", 4'b0110, 8'h0A, 8'h03, 1, 8'hFE, 5'b10000);
    run_op("and",    4'b0010, 8'hF0, 8'h3C, 1, 8'h30, 5'b00000);
    run_op("or",     4'b0011, 8'h00, 8'h00, 1, 8'h00, 5'b00001);
    run_op("not",    4'b0101, 8'h0F, 8'h00, 1, 8'hF0, 5'b00010);
    run_op("shl3",   4'b0111, 8'h81, 8'd3,  4, 8'h08, 5'b00000);
    run_op("shr9",   4'b1000, 8'h81, 8'd9,  9, 8'h00, 5'b00101);
    run_op("rol9",   4'b1001, 8'h81, 8'd9,  2, 8'h03, 5'b00100);
    run_op("ror1",   4'b1010, 8'h01, 8'd1,  2, 8'h80, 5'b00110);
    run_op("illegal",4'b1100, 8'h12, 8'h34, 1, 8'h00, 5'b00000);
    run_op("shl0",   4'b0111, 8'h5A, 8'd0,  1, 8'h5A, 5'b00000);

    // Backpressure: result must hold and a second request must be ignored.
    @(negedge CLK);
    OPCODE = 4'b0000; DATA1 = 8'h11; DATA2 = 8'h22; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(negedge CLK);
    DATA1 = 8'hFF; DATA2 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      check("bp_vld", OUT_VALID, 1);
      check("bp_inrdy", IN_READY, 0);
      check("bp_data", DATAOUT, 8'h33);
      check("bp_flags", FLAGS, 5'b00000);
      if (i == 2) begin
        OUT_READY = 1'b1;
        IN_VALID = 1'b0;
      end
      @(negedge CLK);
    end
    check("bp_vdrop", OUT_VALID, 0);
    check("bp_inrdy2", IN_READY, 1);
    check("bp_held", DATAOUT, 8'h33);

    // Reset during the second SHIFT cycle of SHR 0xFF by 5.
    OPCODE = 4'b1000; DATA1 = 8'hFF; DATA2 = 8'd5; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("mid_vld", OUT_VALID, 0);
    check("mid_inrdy", IN_READY, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mrst_vld", OUT_VALID, 0);
    check("mrst_data", DATAOUT, 8'h00);
    check("mrst_flags", FLAGS, 5'b00000);
    check("mrst_inrdy", IN_READY, 1);
    repeat (6) @(negedge CLK);
    check("mrst_quiet", OUT_VALID, 0);

    run_op("xor",    4'b0100, 8'hAA, 8'hFF, 1, 8'h55, 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
